// File: rtl/irq_arbiter_pkg.sv
// Shared types and helpers for the interrupt arbiter: source count, FSM states,
// and priority encoding (highest index wins).
package irq_arbiter_pkg;

    localparam int IRQ_N = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } state_t;

    // {valid, index} of the highest set bit; valid=0 means no bit set.
    function automatic logic [2:0] prio_idx(input logic [IRQ_N-1:0] v);
        if (v[2])      return 3'b110;
        else if (v[1]) return 3'b101;
        else if (v[0]) return 3'b100;
        else           return 3'b000;
    endfunction

    function automatic logic [IRQ_N-1:0] idx2onehot(input logic [1:0] idx);
        return IRQ_N'(1'b1) << idx;
    endfunction

endpackage

// File: rtl/irq_arbiter_if.sv
// Interrupt front-end signal bundle: pipeline/CSR controls in, insertion request
// and status out. slave = arbiter side, master = pipeline/driver side.
interface irq_arbiter_if #(parameter int CNT_W = 16);
    import irq_arbiter_pkg::*;

    logic [IRQ_N-1:0] ir_in;
    logic             ie;
    logic             en;
    logic             flush;
    logic             int_taken;
    logic             uret_commit;
    logic             Int_Enter;
    logic [IRQ_N-1:0] IRS;
    logic [IRQ_N-1:0] pending;
    logic [IRQ_N-1:0] in_service;
    logic [CNT_W-1:0] int_cnt;

    modport slave (
        input  ir_in, ie, en, flush, int_taken, uret_commit,
        output Int_Enter, IRS, pending, in_service, int_cnt
    );

    modport master (
        output ir_in, ie, en, flush, int_taken, uret_commit,
        input  Int_Enter, IRS, pending, in_service, int_cnt
    );

endinterface

// File: rtl/irq_edge_sync.sv
// Two-flop synchroniser plus rising-edge detect for one interrupt line.
// Pulse appears 2 cycles after the input rises; no backpressure.
module irq_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic [1:0] sync_q;
    logic       edge_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], async_in};
            edge_q <= sync_q[1];
        end
    end

    assign rise = sync_q[1] & ~edge_q;

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: latches edges as pending, nests by priority, and holds Int_Enter/IRS
// until the ID/EX register accepts (en & ~flush); request issued 1 cycle after eligibility.
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    irq_arbiter_if.slave   bus
);

    logic [IRQ_N-1:0] rise;

    genvar g;
    generate
        for (g = 0; g < IRQ_N; g++) begin : g_sync
            irq_edge_sync u_sync (
                .clk      (clk),
                .rst      (rst),
                .async_in (bus.ir_in[g]),
                .rise     (rise[g])
            );
        end
    endgenerate

    state_t           state_q, state_d;
    logic             int_enter_q, int_enter_d;
    logic [IRQ_N-1:0] irs_q, irs_d;
    logic [IRQ_N-1:0] pending_q, in_service_q;
    logic [CNT_W-1:0] int_cnt_q;

    logic [2:0]       hp, cur;
    logic             eligible, accept;
    logic [IRQ_N-1:0] accept_set, uret_clr;

    assign hp  = prio_idx(pending_q);
    assign cur = prio_idx(in_service_q);

    // A uret in flight blocks issue so the priority compare never sees a stale level.
    assign eligible   = bus.ie & hp[2] & (~cur[2] | (hp[1:0] > cur[1:0])) & ~bus.uret_commit;
    assign accept     = (state_q == ST_REQ) & bus.en & ~bus.flush;
    assign accept_set = accept ? irs_q : '0;
    assign uret_clr   = (bus.uret_commit & cur[2]) ? idx2onehot(cur[1:0]) : '0;

    always_comb begin
        state_d     = state_q;
        int_enter_d = int_enter_q;
        irs_d       = irs_q;
        case (state_q)
            ST_IDLE: begin
                if (eligible) begin
                    state_d     = ST_REQ;
                    int_enter_d = 1'b1;
                    irs_d       = idx2onehot(hp[1:0]);
                end
            end
            ST_REQ: begin
                if (accept) begin
                    state_d     = ST_WAIT;
                    int_enter_d = 1'b0;
                    irs_d       = '0;
                end
            end
            ST_WAIT: begin
                if (bus.int_taken) state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                int_enter_d = 1'b0;
                irs_d       = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            int_enter_q <= 1'b0;
            irs_q       <= '0;
        end else begin
            state_q     <= state_d;
            int_enter_q <= int_enter_d;
            irs_q       <= irs_d;
        end
    end

    // New edges are OR'd in after the accept clear so a coincident edge survives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q    <= '0;
            in_service_q <= '0;
            int_cnt_q    <= '0;
        end else begin
            pending_q    <= (pending_q & ~accept_set) | rise;
            in_service_q <= (in_service_q & ~uret_clr) | accept_set;
            if (accept && (int_cnt_q != '1)) int_cnt_q <= int_cnt_q + 1'b1;
        end
    end

    assign bus.Int_Enter  = int_enter_q;
    assign bus.IRS        = irs_q;
    assign bus.pending    = pending_q;
    assign bus.in_service = in_service_q;
    assign bus.int_cnt    = int_cnt_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: vector table for the basic request/stall path,
// hand sequences for masking, coincident events, async reset, nesting, saturation.
module tb_irq_arbiter;
    import irq_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    irq_arbiter_if #(.CNT_W(16)) ifa ();
    irq_arbiter_if #(.CNT_W(2))  ifb ();

    assign ifb.ir_in       = ifa.ir_in;
    assign ifb.ie          = ifa.ie;
    assign ifb.en          = ifa.en;
    assign ifb.flush       = ifa.flush;
    assign ifb.int_taken   = ifa.int_taken;
    assign ifb.uret_commit = ifa.uret_commit;

    irq_arbiter #(.CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(ifa));
    irq_arbiter #(.CNT_W(2))  u_sat (.clk(clk), .rst(rst), .bus(ifb));

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [2:0]  ir;
        logic        ie, en, fl, tk, ur;
        logic        ie_o;
        logic [2:0]  irs, pend, isvc;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic ie_e, input logic [2:0] irs_e,
                             input logic [2:0] pend_e, input logic [2:0] isvc_e,
                             input logic [15:0] cnt_e);
        chk({tag, ".Int_Enter"},  16'(ifa.Int_Enter),  16'(ie_e));
        chk({tag, ".IRS"},        16'(ifa.IRS),        16'(irs_e));
        chk({tag, ".pending"},    16'(ifa.pending),    16'(pend_e));
        chk({tag, ".in_service"}, 16'(ifa.in_service), 16'(isvc_e));
        chk({tag, ".int_cnt"},    ifa.int_cnt,         cnt_e);
    endtask

    task automatic set_in(input logic [2:0] ir, input logic ie, input logic en,
                          input logic fl, input logic tk, input logic ur);
        ifa.ir_in       = ir;
        ifa.ie          = ie;
        ifa.en          = en;
        ifa.flush       = fl;
        ifa.int_taken   = tk;
        ifa.uret_commit = ur;
    endtask

    // Raise lines for two cycles; pending is visible on return (3rd edge).
    task automatic edge_in(input logic [2:0] m);
        ifa.ir_in = m;
        tick();
        tick();
        ifa.ir_in = 3'b000;
        tick();
    endtask

    // From IDLE with an eligible pending source and en=1: request, accept, optional handler entry.
    task automatic take(input string tag, input logic [2:0] irs_e, input logic [2:0] isvc_e,
                        input logic [15:0] cnt_e, input bit leave);
        tick();
        chk({tag, ".req"}, 16'(ifa.Int_Enter), 16'd1);
        chk({tag, ".irs"}, 16'(ifa.IRS),       16'(irs_e));
        tick();
        check_all({tag, ".acc"}, 1'b0, 3'b000, 3'b000, isvc_e, cnt_e);
        if (leave) begin
            ifa.int_taken = 1'b1;
            tick();
            ifa.int_taken = 1'b0;
        end
    endtask

    initial begin
        //          ir      ie    en    fl    tk    ur    IE    irs     pend    isvc    cnt
        tbl[0]  = '{3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 16'd0};
        tbl[1]  = '{3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 16'd0};
        tbl[2]  = '{3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b001, 3'b000, 16'd0};
        tbl[3]  = '{3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 3'b001, 3'b000, 16'd0};
        tbl[4]  = '{3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b001, 16'd1};
        tbl[5]  = '{3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b001, 16'd1};
        tbl[6]  = '{3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b001, 16'd1};
        tbl[7]  = '{3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b001, 16'd1};
        tbl[8]  = '{3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b001, 16'd1};
        tbl[9]  = '{3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b010, 3'b001, 16'd1};
        tbl[10] = '{3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 3'b010, 3'b001, 16'd1};
        tbl[11] = '{3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 3'b010, 3'b001, 16'd1};
        tbl[12] = '{3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 3'b010, 3'b001, 16'd1};
        tbl[13] = '{3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 3'b010, 3'b001, 16'd1};
        tbl[14] = '{3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 3'b010, 3'b001, 16'd1};
        tbl[15] = '{3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b011, 16'd2};
        tbl[16] = '{3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b011, 16'd2};
        tbl[17] = '{3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 3'b001, 16'd2};
        tbl[18] = '{3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 16'd2};
        tbl[19] = '{3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 16'd2};

        rst = 1'b0;
        set_in(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        check_all("reset", 1'b0, 3'b000, 3'b000, 3'b000, 16'd0);
        chk("reset.sat_cnt", 16'(ifb.int_cnt), 16'd0);
        tick();
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            set_in(tbl[i].ir, tbl[i].ie, tbl[i].en, tbl[i].fl, tbl[i].tk, tbl[i].ur);
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].ie_o, tbl[i].irs, tbl[i].pend,
                      tbl[i].isvc, tbl[i].cnt);
        end
        chk("sat_cnt_2", 16'(ifb.int_cnt), 16'd2);

        // Masking: pending source 2 with ie=0 must not request.
        set_in(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        edge_in(3'b100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("masked%0d.Int_Enter", i), 16'(ifa.Int_Enter), 16'd0);
            chk($sformatf("masked%0d.pending", i),   16'(ifa.pending),   16'(3'b100));
        end
        ifa.ie = 1'b1;
        ifa.en = 1'b0;
        tick();
        chk("unmask.Int_Enter", 16'(ifa.Int_Enter), 16'd1);
        chk("unmask.IRS",       16'(ifa.IRS),       16'(3'b100));

        // ie drop in REQ holds; new source-2 edge lands on the accept edge.
        ifa.ie    = 1'b0;
        ifa.ir_in = 3'b100;
        tick();
        chk("ie_drop.Int_Enter", 16'(ifa.Int_Enter), 16'd1);
        tick();
        chk("ie_drop2.IRS", 16'(ifa.IRS), 16'(3'b100));
        ifa.ir_in = 3'b000;
        ifa.en    = 1'b1;
        tick();
        check_all("simul", 1'b0, 3'b000, 3'b100, 3'b100, 16'd3);
        chk("sat_cnt_3", 16'(ifb.int_cnt), 16'd3);

        ifa.int_taken = 1'b1;
        tick();
        ifa.int_taken = 1'b0;
        ifa.ie        = 1'b1;
        tick();
        check_all("eq_prio", 1'b0, 3'b000, 3'b100, 3'b100, 16'd3);

        ifa.uret_commit = 1'b1;
        tick();
        ifa.uret_commit = 1'b0;
        check_all("uret_pop", 1'b0, 3'b000, 3'b100, 3'b000, 16'd3);
        take("retake2", 3'b100, 3'b100, 16'd4, 1'b1);
        chk("sat_cnt_4", 16'(ifb.int_cnt), 16'd3);

        ifa.uret_commit = 1'b1;
        tick();
        ifa.uret_commit = 1'b0;
        edge_in(3'b010);
        take("src1_wait", 3'b010, 3'b010, 16'd5, 1'b0);
        chk("sat_cnt_5", 16'(ifb.int_cnt), 16'd3);

        // Async reset mid-WAIT, observed before any further clock edge.
        #2;
        rst = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 3'b000, 3'b000, 3'b000, 16'd0);
        chk("async_rst.sat_cnt", 16'(ifb.int_cnt), 16'd0);
        tick();
        rst = 1'b1;

        // Nesting by priority.
        set_in(3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        edge_in(3'b001);
        take("nest0", 3'b001, 3'b001, 16'd1, 1'b1);
        edge_in(3'b100);
        take("nest2", 3'b100, 3'b101, 16'd2, 1'b1);
        edge_in(3'b010);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("blocked%0d.Int_Enter", i), 16'(ifa.Int_Enter), 16'd0);
            chk($sformatf("blocked%0d.pending", i),   16'(ifa.pending),   16'(3'b010));
        end
        ifa.uret_commit = 1'b1;
        tick();
        ifa.uret_commit = 1'b0;
        check_all("nest_uret", 1'b0, 3'b000, 3'b010, 3'b001, 16'd2);
        take("nest1", 3'b010, 3'b011, 16'd3, 1'b1);

        // uret and acceptance in the same cycle: pop bit 1, then set bit 2.
        edge_in(3'b100);
        tick();
        chk("uacc.req", 16'(ifa.IRS), 16'(3'b100));
        ifa.uret_commit = 1'b1;
        tick();
        ifa.uret_commit = 1'b0;
        check_all("uret_acc", 1'b0, 3'b000, 3'b000, 3'b101, 16'd4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
